// File: rtl/divide_int16_int32_seq.sv
// Iterative signed fixed-point divider, restoring radix-2, one quotient bit per cycle.
// Joins a dividend and a divisor beat; returns a Q(DIVIDEND_WIDTH).(FRAC_BITS) quotient.
module divide_int16_int32_seq #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 32,
  parameter int FRAC_BITS      = 32
) (
  input  logic                                    aclk,
  input  logic                                    aresetn,
  input  logic                                    clear,
  input  logic [DIVIDEND_WIDTH-1:0]               s_axis_dividend_tdata,
  input  logic                                    s_axis_dividend_tlast,
  input  logic                                    s_axis_dividend_tvalid,
  output logic                                    s_axis_dividend_tready,
  input  logic [DIVISOR_WIDTH-1:0]                s_axis_divisor_tdata,
  input  logic                                    s_axis_divisor_tlast,
  input  logic                                    s_axis_divisor_tvalid,
  output logic                                    s_axis_divisor_tready,
  output logic [DIVIDEND_WIDTH+FRAC_BITS-1:0]     m_axis_dout_tdata,
  output logic                                    m_axis_dout_tuser,
  output logic                                    m_axis_dout_tlast,
  output logic                                    m_axis_dout_tvalid,
  input  logic                                    m_axis_dout_tready
);

  localparam int OUT_WIDTH = DIVIDEND_WIDTH + FRAC_BITS;
  localparam int ITER      = OUT_WIDTH;
  localparam int CW        = $clog2(ITER + 1);
  localparam int RW        = DIVISOR_WIDTH + 1;

  localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX,
    S_OUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [OUT_WIDTH-1:0]      num;
  logic [DIVISOR_WIDTH-1:0]  den;
  logic [RW-1:0]             rem;
  logic [OUT_WIDTH-1:0]      quo;
  logic [CW-1:0]             cnt;
  logic                      neg;
  logic                      zf;
  logic                      zneg;
  logic                      last;

  logic                      join_ok;
  logic                      dvd_neg;
  logic                      dvs_neg;
  logic [DIVIDEND_WIDTH-1:0] dvd_mag;
  logic [DIVISOR_WIDTH-1:0]  dvs_mag;
  logic [RW:0]               rem_sh;
  logic [RW:0]               diff;
  logic                      ge;
  logic [RW-1:0]             rem_nxt;
  logic                      div_done;
  logic [OUT_WIDTH-1:0]      fix_data;

  // A lone valid is never consumed; both beats go on the same edge.
  assign join_ok = aresetn && !clear && (state == S_IDLE)
                   && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
  assign s_axis_dividend_tready = join_ok;
  assign s_axis_divisor_tready  = join_ok;

  assign dvd_neg = s_axis_dividend_tdata[DIVIDEND_WIDTH-1];
  assign dvs_neg = s_axis_divisor_tdata[DIVISOR_WIDTH-1];
  assign dvd_mag = dvd_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
  assign dvs_mag = dvs_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;

  // Single subtractor: the borrow out of diff decides the quotient bit.
  assign rem_sh   = {rem, num[OUT_WIDTH-1]};
  assign diff     = rem_sh - {2'b00, den};
  assign ge       = !diff[RW];
  assign rem_nxt  = ge ? diff[RW-1:0] : rem_sh[RW-1:0];
  assign div_done = (cnt == CW'(ITER - 1));

  always_comb begin
    fix_data = neg ? -quo : quo;
    if (zf) begin
      fix_data = zneg ? MIN_NEG : MAX_POS;
    end else if ((quo == MIN_NEG) && !neg) begin
      fix_data = MAX_POS;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (join_ok) state_nxt = S_DIV;
      S_DIV:   if (div_done) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_OUT;
      S_OUT:   if (m_axis_dout_tready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_IDLE;
    end else if (clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      num                <= '0;
      den                <= '0;
      rem                <= '0;
      quo                <= '0;
      cnt                <= '0;
      neg                <= 1'b0;
      zf                 <= 1'b0;
      zneg               <= 1'b0;
      last               <= 1'b0;
      m_axis_dout_tdata  <= '0;
      m_axis_dout_tuser  <= 1'b0;
      m_axis_dout_tlast  <= 1'b0;
      m_axis_dout_tvalid <= 1'b0;
    end else if (clear) begin
      num                <= '0;
      den                <= '0;
      rem                <= '0;
      quo                <= '0;
      cnt                <= '0;
      neg                <= 1'b0;
      zf                 <= 1'b0;
      zneg               <= 1'b0;
      last               <= 1'b0;
      m_axis_dout_tdata  <= '0;
      m_axis_dout_tuser  <= 1'b0;
      m_axis_dout_tlast  <= 1'b0;
      m_axis_dout_tvalid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (join_ok) begin
            num  <= {dvd_mag, {FRAC_BITS{1'b0}}};
            den  <= dvs_mag;
            neg  <= dvd_neg ^ dvs_neg;
            zf   <= (s_axis_divisor_tdata == '0);
            zneg <= dvd_neg;
            last <= s_axis_dividend_tlast | s_axis_divisor_tlast;
            rem  <= '0;
            quo  <= '0;
            cnt  <= '0;
          end
        end
        S_DIV: begin
          num <= num << 1;
          rem <= rem_nxt;
          quo <= {quo[OUT_WIDTH-2:0], ge};
          cnt <= cnt + CW'(1);
        end
        S_FIX: begin
          m_axis_dout_tdata  <= fix_data;
          m_axis_dout_tuser  <= zf;
          m_axis_dout_tlast  <= last;
          m_axis_dout_tvalid <= 1'b1;
        end
        S_OUT: begin
          if (m_axis_dout_tready) m_axis_dout_tvalid <= 1'b0;
        end
        default: begin
          m_axis_dout_tvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divide_int16_int32_seq.sv
// Directed and randomized checks for the sequential fixed-point divider.
// Inputs change #1 after rising edges; outputs are sampled on falling edges.
module tb_divide_int16_int32_seq;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        clear;
  logic [15:0] dvd_tdata;
  logic        dvd_tlast;
  logic        dvd_tvalid;
  logic        dvd_tready;
  logic [31:0] dvs_tdata;
  logic        dvs_tlast;
  logic        dvs_tvalid;
  logic        dvs_tready;
  logic [47:0] dout_tdata;
  logic        dout_tuser;
  logic        dout_tlast;
  logic        dout_tvalid;
  logic        dout_tready;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  divide_int16_int32_seq dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .clear                  (clear),
    .s_axis_dividend_tdata  (dvd_tdata),
    .s_axis_dividend_tlast  (dvd_tlast),
    .s_axis_dividend_tvalid (dvd_tvalid),
    .s_axis_dividend_tready (dvd_tready),
    .s_axis_divisor_tdata   (dvs_tdata),
    .s_axis_divisor_tlast   (dvs_tlast),
    .s_axis_divisor_tvalid  (dvs_tvalid),
    .s_axis_divisor_tready  (dvs_tready),
    .m_axis_dout_tdata      (dout_tdata),
    .m_axis_dout_tuser      (dout_tuser),
    .m_axis_dout_tlast      (dout_tlast),
    .m_axis_dout_tvalid     (dout_tvalid),
    .m_axis_dout_tready     (dout_tready)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] model(input logic [15:0] a,
                                        input logic [31:0] b);
    longint x;
    longint y;
    longint q;
    longint maxp;
    maxp = 64'sh0000_7FFF_FFFF_FFFF;
    x = longint'($signed(a)) * 64'sd4294967296;
    y = longint'($signed(b));
    if (y == 0) begin
      q = a[15] ? -(maxp + 1) : maxp;
    end else begin
      q = x / y;
      if (q > maxp) q = maxp;
    end
    return q[47:0];
  endfunction

  task automatic send(input logic [15:0] a, input logic [31:0] b,
                      input logic la, input logic lb,
                      input int d1, input int d2);
    logic hs;
    hs = 1'b0;
    dvd_tdata = a;
    dvs_tdata = b;
    dvd_tlast = la;
    dvs_tlast = lb;
    for (int c = 0; c < 200; c++) begin
      if (c >= d1) dvd_tvalid = 1'b1;
      if (c >= d2) dvs_tvalid = 1'b1;
      @(negedge aclk);
      hs = dvd_tready && dvs_tready;
      @(posedge aclk);
      #1;
      if (hs) break;
    end
    dvd_tvalid = 1'b0;
    dvs_tvalid = 1'b0;
    if (!hs) chk("in_timeout", 64'(hs), 64'd1);
  endtask

  task automatic recv(input string tag, input logic [47:0] ed,
                      input logic eu, input logic el,
                      input int hold, input int lat);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge aclk);
      if (dout_tvalid) got = 1'b1;
      else begin
        @(posedge aclk);
        n++;
      end
    end
    chk({tag, "_vld"}, 64'(got), 64'd1);
    if (!got) return;
    if (lat > 0) chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_data"}, 64'(dout_tdata), 64'(ed));
    chk({tag, "_user"}, 64'(dout_tuser), 64'(eu));
    chk({tag, "_last"}, 64'(dout_tlast), 64'(el));
    for (int i = 0; i < hold; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      chk({tag, "_hvld"}, 64'(dout_tvalid), 64'd1);
      chk({tag, "_hdat"}, 64'(dout_tdata), 64'(ed));
      chk({tag, "_hrdy"}, 64'({dvd_tready, dvs_tready}), 64'd0);
    end
    dout_tready = 1'b1;
    @(posedge aclk);
    #1;
    dout_tready = 1'b0;
    chk({tag, "_drop"}, 64'(dout_tvalid), 64'd0);
  endtask

  task automatic run(input string tag, input logic [15:0] a,
                     input logic [31:0] b, input logic la,
                     input logic lb, input logic [47:0] ed,
                     input logic eu, input logic el);
    send(a, b, la, lb, 0, 0);
    recv(tag, ed, eu, el, 0, 49);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra;
    logic [31:0] rb;
    logic        rla;
    logic        rlb;
    aresetn     = 1'b0;
    clear       = 1'b0;
    dvd_tdata   = '0;
    dvs_tdata   = '0;
    dvd_tlast   = 1'b0;
    dvs_tlast   = 1'b0;
    dvd_tvalid  = 1'b1;
    dvs_tvalid  = 1'b1;
    dout_tready = 1'b0;
    #12;
    chk("rst_vld", 64'(dout_tvalid), 64'd0);
    chk("rst_dat", 64'(dout_tdata), 64'd0);
    chk("rst_usr", 64'({dout_tuser, dout_tlast}), 64'd0);
    chk("rst_rdy", 64'({dvd_tready, dvs_tready}), 64'd0);
    dvd_tvalid = 1'b0;
    dvs_tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    run("d1_1", 16'd1, 32'd1, 0, 0, 48'h0001_0000_0000, 0, 0);
    run("d3_2", 16'd3, 32'd2, 0, 0, 48'h0001_8000_0000, 0, 0);
    run("dm1_3", 16'hFFFF, 32'd3, 0, 0, 48'hFFFF_AAAA_AAAB, 0, 0);
    run("d7_min", 16'd7, 32'h8000_0000, 0, 0, 48'hFFFF_FFFF_FFF2, 0, 0);
    run("d5_0", 16'd5, 32'd0, 0, 0, 48'h7FFF_FFFF_FFFF, 1, 0);
    run("dm5_0", 16'hFFFB, 32'd0, 0, 0, 48'h8000_0000_0000, 1, 0);
    run("dmin_m1", 16'h8000, 32'hFFFF_FFFF, 0, 0, 48'h7FFF_FFFF_FFFF, 0, 0);
    run("dmin_1", 16'h8000, 32'd1, 0, 0, 48'h8000_0000_0000, 0, 0);
    run("last_dvs", 16'd1, 32'd2, 0, 1, 48'h0000_8000_0000, 0, 1);
    run("last_dvd", 16'd1, 32'd2, 1, 0, 48'h0000_8000_0000, 0, 1);

    dvd_tdata  = 16'd9;
    dvd_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("join_lone", 64'({dvd_tready, dvs_tready}), 64'd0);
      @(posedge aclk);
      #1;
    end
    send(16'd9, 32'd4, 0, 0, 0, 0);
    recv("join", 48'h0002_4000_0000, 0, 0, 0, 49);

    send(16'd3, 32'd2, 0, 0, 0, 0);
    dvd_tdata  = 16'd1;
    dvs_tdata  = 32'd1;
    dvd_tvalid = 1'b1;
    dvs_tvalid = 1'b1;
    recv("hold", 48'h0001_8000_0000, 0, 0, 20, 49);
    dvd_tvalid = 1'b0;
    dvs_tvalid = 1'b0;

    send(16'd1, 32'd1, 0, 0, 0, 0);
    repeat (10) @(posedge aclk);
    #2;
    dvd_tvalid = 1'b1;
    dvs_tvalid = 1'b1;
    aresetn    = 1'b0;
    #1;
    chk("arst_vld", 64'(dout_tvalid), 64'd0);
    chk("arst_dat", 64'(dout_tdata), 64'd0);
    chk("arst_rdy", 64'({dvd_tready, dvs_tready}), 64'd0);
    @(negedge aclk);
    dvd_tvalid = 1'b0;
    dvs_tvalid = 1'b0;
    aresetn    = 1'b1;
    @(posedge aclk);
    #1;
    run("arst_6_3", 16'd6, 32'd3, 0, 0, 48'h0002_0000_0000, 0, 0);

    send(16'd5, 32'd2, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (dout_tvalid) break;
    end
    chk("clr_pre", 64'(dout_tvalid), 64'd1);
    clear = 1'b1;
    @(posedge aclk);
    #1;
    clear = 1'b0;
    chk("clr_vld", 64'(dout_tvalid), 64'd0);
    chk("clr_dat", 64'(dout_tdata), 64'd0);
    run("clr_next", 16'd1, 32'd4, 0, 0, 48'h0000_4000_0000, 0, 0);

    for (int k = 0; k < 200; k++) begin
      ra  = 16'($urandom);
      rb  = (k % 3 == 0) ? 32'($urandom_range(0, 70000)) : 32'($urandom);
      if (k % 6 == 3) rb = -rb;
      rla = 1'($urandom);
      rlb = 1'($urandom);
      send(ra, rb, rla, rlb, $urandom_range(0, 3), $urandom_range(0, 3));
      recv("rnd", model(ra, rb), (rb == 32'd0), rla | rlb,
           $urandom_range(0, 3), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
